branch_pc_sequencer: RTL and testbench

//  PC/nPC sequencing stage directly downstream of the branch logic (bla) and upstream of the PC input mux.

---
 rtl/branch_pc_sequencer.sv | 126 ++++++++++++
 tb/tb_branch_pc_sequencer.sv | 153 +++++++++++++++
 2 files changed

// File: rtl/branch_pc_sequencer.sv
// SPARC V8 PC/nPC sequencer: delayed control transfer, delay-slot annulment, JMPL and trap redirects.
// Optional BRANCH_STATS_EN adds taken/annul event counters.
module branch_pc_sequencer #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] RESET_NPC = 32'h0000_0004
) (
  input  logic        Clk,
  input  logic        RESET,
  input  logic        advance,
  input  logic        is_bicc,
  input  logic        annul_bit,
  input  logic        cond,
  input  logic        ba,
  input  logic        bn,
  input  logic [21:0] disp22,
  input  logic        jmpl_req,
  input  logic [31:0] jmpl_target,
  input  logic        trap_req,
  input  logic [31:0] trap_vec,
  output logic [31:0] pc,
  output logic [31:0] npc,
  output logic        annul_slot,
`ifdef BRANCH_STATS_EN
  output logic [31:0] taken_cnt,
  output logic [31:0] annul_cnt,
`endif
  output logic        align_err
);

  typedef enum logic {RUN = 1'b0, ANNUL = 1'b1} state_t;

  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d, npc_q, npc_d;
  logic        align_q, align_d;
  logic [31:0] br_tgt;
  logic        taken, misalign;

  // ba=bn=1 is illegal; ba dominates so it reads as branch-always
  assign taken    = ba | (cond & ~bn);
  assign br_tgt   = pc_q + {{8{disp22[21]}}, disp22, 2'b00};
  assign misalign = |jmpl_target[1:0];

  always_ff @(posedge Clk) begin
    if (RESET) state_q <= RUN;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (advance) begin
      if (trap_req || state_q == ANNUL || jmpl_req) state_d = RUN;
      else if (is_bicc && annul_bit && (!taken || ba)) state_d = ANNUL;
      else state_d = RUN;
    end
  end

  always_comb begin
    annul_slot = (state_q == ANNUL);
  end

  // align_err defaults low so the pulse self-clears on the next edge
  always_comb begin
    pc_d    = pc_q;
    npc_d   = npc_q;
    align_d = 1'b0;
    if (advance) begin
      if (trap_req) begin
        pc_d  = trap_vec;
        npc_d = trap_vec + 32'd4;
      end else if (state_q == ANNUL) begin
        pc_d  = npc_q;
        npc_d = npc_q + 32'd4;
      end else if (jmpl_req) begin
        if (misalign) align_d = 1'b1;
        else begin
          pc_d  = npc_q;
          npc_d = jmpl_target;
        end
      end else if (is_bicc) begin
        pc_d  = npc_q;
        npc_d = taken ? br_tgt : npc_q + 32'd4;
      end else begin
        pc_d  = npc_q;
        npc_d = npc_q + 32'd4;
      end
    end
  end

  always_ff @(posedge Clk) begin
    if (RESET) begin
      pc_q    <= RESET_PC;
      npc_q   <= RESET_NPC;
      align_q <= 1'b0;
    end else begin
      pc_q    <= pc_d;
      npc_q   <= npc_d;
      align_q <= align_d;
    end
  end

  assign pc        = pc_q;
  assign npc       = npc_q;
  assign align_err = align_q;

`ifdef BRANCH_STATS_EN
  logic [31:0] taken_cnt_q, annul_cnt_q;
  logic        ev_taken, ev_annul;

  assign ev_taken = advance && !trap_req && state_q == RUN && !jmpl_req && is_bicc && taken;
  assign ev_annul = advance && !trap_req && state_q == ANNUL;

  always_ff @(posedge Clk) begin
    if (RESET) begin
      taken_cnt_q <= '0;
      annul_cnt_q <= '0;
    end else begin
      if (ev_taken) taken_cnt_q <= taken_cnt_q + 32'd1;
      if (ev_annul) annul_cnt_q <= annul_cnt_q + 32'd1;
    end
  end

  assign taken_cnt = taken_cnt_q;
  assign annul_cnt = annul_cnt_q;
`endif

endmodule

// File: tb/tb_branch_pc_sequencer.sv
// Bench for branch_pc_sequencer: directed scenarios then random retirement streams vs a reference model.
module tb_branch_pc_sequencer;

  logic        Clk = 1'b0;
  logic        RESET, advance, is_bicc, annul_bit, cond, ba, bn, jmpl_req, trap_req;
  logic [21:0] disp22;
  logic [31:0] jmpl_target, trap_vec;
  logic [31:0] pc, npc;
  logic        annul_slot, align_err;

  int checks = 0;
  int passed = 0;

  // reference architectural state
  logic [31:0] m_pc, m_npc;
  logic        m_squash, m_align;

  always #5 Clk = ~Clk;

  branch_pc_sequencer dut (
    .Clk(Clk), .RESET(RESET), .advance(advance), .is_bicc(is_bicc), .annul_bit(annul_bit),
    .cond(cond), .ba(ba), .bn(bn), .disp22(disp22), .jmpl_req(jmpl_req),
    .jmpl_target(jmpl_target), .trap_req(trap_req), .trap_vec(trap_vec),
    .pc(pc), .npc(npc), .annul_slot(annul_slot), .align_err(align_err)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  // SPARC V8 delayed-branch rules applied to the architectural state for one clock edge
  task automatic model_edge();
    logic        br_taken;
    logic [31:0] old_npc;
    if (RESET) begin
      m_pc = 32'h0; m_npc = 32'h4; m_squash = 1'b0; m_align = 1'b0;
      return;
    end
    m_align = 1'b0;
    if (!advance) return;
    old_npc = m_npc;
    if (trap_req) begin
      m_pc = trap_vec; m_npc = trap_vec + 4; m_squash = 1'b0;
    end else if (m_squash) begin
      m_pc = old_npc; m_npc = old_npc + 4; m_squash = 1'b0;
    end else if (jmpl_req) begin
      if (jmpl_target % 4 != 0) m_align = 1'b1;
      else begin m_pc = old_npc; m_npc = jmpl_target; end
    end else if (is_bicc) begin
      br_taken = ba || (cond && !bn);
      m_npc = br_taken ? m_pc + (32'(signed'(disp22)) * 4) : old_npc + 4;
      m_pc  = old_npc;
      m_squash = annul_bit && (!br_taken || ba);
    end else begin
      m_pc = old_npc; m_npc = old_npc + 4;
    end
  endtask

  task automatic clk_and_check(input string tag);
    @(posedge Clk);
    model_edge();
    #1;
    check({tag, ".pc"}, pc, m_pc);
    check({tag, ".npc"}, npc, m_npc);
    check({tag, ".annul"}, 32'(annul_slot), 32'(m_squash));
    check({tag, ".align"}, 32'(align_err), 32'(m_align));
  endtask

  task automatic idle();
    RESET = 0; advance = 0; is_bicc = 0; annul_bit = 0; cond = 0; ba = 0; bn = 0;
    disp22 = '0; jmpl_req = 0; jmpl_target = '0; trap_req = 0; trap_vec = '0;
  endtask

  task automatic bicc(input logic a, input logic c, input logic b_a, input logic b_n,
                      input logic [21:0] d, input string tag);
    idle(); advance = 1; is_bicc = 1; annul_bit = a; cond = c; ba = b_a; bn = b_n; disp22 = d;
    clk_and_check(tag);
  endtask

  task automatic do_reset(input string tag);
    idle(); RESET = 1; advance = 1; trap_req = 1; trap_vec = 32'h1230; is_bicc = 1; ba = 1;
    clk_and_check(tag);
    check({tag, ".pc0"}, pc, 32'h0);
    check({tag, ".npc4"}, npc, 32'h4);
  endtask

  initial begin
    idle();
    do_reset("rst");
    check("rst.annul0", 32'(annul_slot), 32'h0);

    idle(); advance = 1; clk_and_check("seq");
    check("seq.pc", pc, 32'h4);
    check("seq.npc", npc, 32'h8);
    idle(); clk_and_check("hold");

    do_reset("t2rst");
    bicc(0, 0, 1, 0, 22'd3, "ba_a0");
    check("ba_a0.tgt", npc, 32'd12);

    do_reset("t3rst");
    bicc(1, 0, 0, 1, 22'd9, "bn_a1");
    check("bn_a1.annul", 32'(annul_slot), 32'h1);
    bicc(0, 0, 1, 0, 22'd100, "annul_ignores");
    check("annul_ignores.npc", npc, 32'd12);

    do_reset("t4rst");
    bicc(1, 1, 0, 0, 22'd5, "ble_taken");
    check("ble_taken.npc", npc, 32'd20);
    do_reset("t4rst2");
    bicc(1, 0, 0, 0, 22'd5, "ble_not");
    check("ble_not.npc", npc, 32'd8);

    do_reset("t5rst");
    bicc(0, 0, 1, 0, 22'h3FFFFF, "wrap");
    check("wrap.npc", npc, 32'hFFFF_FFFC);
    idle(); advance = 1; jmpl_req = 1; jmpl_target = 32'h102; clk_and_check("jmpl_mis");
    check("jmpl_mis.align", 32'(align_err), 32'h1);
    idle(); clk_and_check("align_clr");
    idle(); advance = 1; jmpl_req = 1; jmpl_target = 32'h400; clk_and_check("jmpl_ok");

    do_reset("t6rst");
    bicc(1, 0, 0, 1, 22'd1, "t6_annul");
    idle(); advance = 1; trap_req = 1; trap_vec = 32'h800; clk_and_check("trap");
    check("trap.pc", pc, 32'h800);
    check("trap.npc", npc, 32'h804);
    do_reset("rst_wins");

    for (int i = 0; i < 500; i++) begin
      idle();
      RESET       = ($urandom_range(0, 39) == 0);
      advance     = ($urandom_range(0, 3) != 0);
      trap_req    = ($urandom_range(0, 19) == 0);
      trap_vec    = {$urandom_range(0, 255), 4'h0} << 4;
      jmpl_req    = ($urandom_range(0, 9) == 0);
      jmpl_target = $urandom;
      if ($urandom_range(0, 1)) jmpl_target[1:0] = 2'b00;
      is_bicc     = ($urandom_range(0, 9) < 4);
      annul_bit   = $urandom_range(0, 1);
      cond        = $urandom_range(0, 1);
      ba          = ($urandom_range(0, 3) == 0);
      bn          = ($urandom_range(0, 3) == 0);
      disp22      = 22'($urandom);
      clk_and_check($sformatf("rnd%0d", i));
    end

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
